// File: rtl/game_pkg.sv
// Shared definitions for the obstacle game: state encoding, screen geometry
// and counter types used by the sequencer and the movement/render datapath.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam int SCREEN_W   = 1920;
    localparam int SCREEN_H   = 1080;
    localparam int GAP_H      = 400;
    localparam int OBSTACLE_W = 200;

    typedef logic [21:0] step_t;
    typedef logic [7:0]  frame_t;
    typedef logic [3:0]  speed_t;

    // Even offset 0..510 on top of the base keeps the gap inside the screen.
    function automatic logic [10:0] gap_from_lfsr(input logic [7:0] rnd, input logic [10:0] base);
        return base + {2'b00, rnd, 1'b0};
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer (master) and the movement/render
// datapath plus button/VGA timing logic (slave).
interface game_sequencer_if;
    import game_pkg::*;

    logic        frame_start;
    logic        start_pulse;
    logic        collision;
    logic        obstacle_done;
    game_state_t state;
    logic        obstacle_step;
    logic        spawn;
    logic [10:0] gap_y;
    logic        player_reset;
    logic        freeze;
    logic [7:0]  score;
    logic [1:0]  lives;

    modport master (
        input  frame_start, start_pulse, collision, obstacle_done,
        output state, obstacle_step, spawn, gap_y, player_reset, freeze, score, lives
    );

    modport slave (
        output frame_start, start_pulse, collision, obstacle_done,
        input  state, obstacle_step, spawn, gap_y, player_reset, freeze, score, lives
    );

endinterface

// File: rtl/game_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
// The low OUT_W bits of the register are exposed.
module game_lfsr16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk_148_mhz,
    input  logic             rst_n,
    output logic [OUT_W-1:0] lfsr_out
);

    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            if (gi == 15) begin : g_top
                assign lfsr_next[gi] = lfsr_reg[0] & TAPS[gi];
            end else begin : g_mid
                assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr_out = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: round sequencing, obstacle step scheduling with
// progressive speed-up, spawn issue with random gap, score and lives.
module game_sequencer
    import game_pkg::*;
#(
    parameter int          STEP_PERIOD_INIT = 300000,
    parameter int          PERIOD_MIN       = 100000,
    parameter int          PERIOD_DEC       = 20000,
    parameter int          SPEEDUP_EVERY    = 5,
    parameter int          LIVES            = 3,
    parameter int          HIT_FRAMES       = 60,
    parameter int          GAP_Y_MIN        = 100,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic             clk_148_mhz,
    input  logic             rst_n,
    game_sequencer_if.master bus
);

    localparam step_t       PERIOD_INIT_V = step_t'(STEP_PERIOD_INIT);
    localparam step_t       PERIOD_MIN_V  = step_t'(PERIOD_MIN);
    localparam step_t       PERIOD_DEC_V  = step_t'(PERIOD_DEC);
    localparam step_t       PERIOD_FLOOR  = step_t'(PERIOD_MIN + PERIOD_DEC);
    localparam frame_t      HIT_LAST      = frame_t'(HIT_FRAMES - 1);
    localparam speed_t      SPEED_LAST    = speed_t'(SPEEDUP_EVERY - 1);
    localparam logic [1:0]  LIVES_V       = 2'(LIVES);
    localparam logic [10:0] GAP_BASE      = 11'(GAP_Y_MIN);

    game_state_t state_reg, state_next;
    step_t       step_cnt_reg, step_cnt_next;
    step_t       period_reg, period_next;
    frame_t      frame_cnt_reg, frame_cnt_next;
    speed_t      speed_cnt_reg, speed_cnt_next;
    logic [7:0]  score_reg, score_next;
    logic [1:0]  lives_reg, lives_next;
    logic [10:0] gap_y_reg, gap_y_next;
    logic        obstacle_step_reg, obstacle_step_next;
    logic        spawn_reg, spawn_next;
    logic        player_reset_reg, player_reset_next;
    logic        freeze_reg, freeze_next;

    logic [7:0]  lfsr_byte;
    logic [10:0] spawn_gap;
    step_t       period_faster;

    game_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (8)
    ) u_lfsr (
        .clk_148_mhz (clk_148_mhz),
        .rst_n       (rst_n),
        .lfsr_out    (lfsr_byte)
    );

    assign spawn_gap     = gap_from_lfsr(lfsr_byte, GAP_BASE);
    assign period_faster = (period_reg >= PERIOD_FLOOR) ? period_reg - PERIOD_DEC_V : PERIOD_MIN_V;

    always_ff @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            step_cnt_reg      <= '0;
            period_reg        <= PERIOD_INIT_V;
            frame_cnt_reg     <= '0;
            speed_cnt_reg     <= '0;
            score_reg         <= '0;
            lives_reg         <= LIVES_V;
            gap_y_reg         <= GAP_BASE;
            obstacle_step_reg <= 1'b0;
            spawn_reg         <= 1'b0;
            player_reset_reg  <= 1'b0;
            freeze_reg        <= 1'b1;
        end else begin
            state_reg         <= state_next;
            step_cnt_reg      <= step_cnt_next;
            period_reg        <= period_next;
            frame_cnt_reg     <= frame_cnt_next;
            speed_cnt_reg     <= speed_cnt_next;
            score_reg         <= score_next;
            lives_reg         <= lives_next;
            gap_y_reg         <= gap_y_next;
            obstacle_step_reg <= obstacle_step_next;
            spawn_reg         <= spawn_next;
            player_reset_reg  <= player_reset_next;
            freeze_reg        <= freeze_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        step_cnt_next      = step_cnt_reg;
        period_next        = period_reg;
        frame_cnt_next     = frame_cnt_reg;
        speed_cnt_next     = speed_cnt_reg;
        score_next         = score_reg;
        lives_next         = lives_reg;
        gap_y_next         = gap_y_reg;
        obstacle_step_next = 1'b0;
        spawn_next         = 1'b0;
        player_reset_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start_pulse) begin
                    state_next        = ST_PLAY;
                    spawn_next        = 1'b1;
                    player_reset_next = 1'b1;
                    gap_y_next        = spawn_gap;
                    score_next        = '0;
                    lives_next        = LIVES_V;
                    period_next       = PERIOD_INIT_V;
                    step_cnt_next     = '0;
                    speed_cnt_next    = '0;
                end
            end

            ST_PLAY: begin
                // A collision pre-empts everything else this cycle, including
                // a simultaneous obstacle_done and the step counter advance.
                if (bus.collision) begin
                    state_next     = ST_HIT;
                    frame_cnt_next = '0;
                    if (lives_reg != 2'd0) begin
                        lives_next = lives_reg - 2'd1;
                    end
                end else begin
                    if (step_cnt_reg >= period_reg - step_t'(1)) begin
                        step_cnt_next      = '0;
                        obstacle_step_next = 1'b1;
                    end else begin
                        step_cnt_next = step_cnt_reg + step_t'(1);
                    end
                    if (bus.obstacle_done) begin
                        spawn_next = 1'b1;
                        gap_y_next = spawn_gap;
                        if (score_reg != 8'hFF) begin
                            score_next = score_reg + 8'd1;
                        end
                        if (speed_cnt_reg == SPEED_LAST) begin
                            speed_cnt_next = '0;
                            period_next    = period_faster;
                        end else begin
                            speed_cnt_next = speed_cnt_reg + speed_t'(1);
                        end
                    end
                end
            end

            ST_HIT: begin
                if (bus.frame_start) begin
                    frame_cnt_next = frame_cnt_reg + frame_t'(1);
                    if (frame_cnt_reg == HIT_LAST) begin
                        if (lives_reg == 2'd0) begin
                            state_next = ST_OVER;
                        end else begin
                            state_next        = ST_PLAY;
                            spawn_next        = 1'b1;
                            player_reset_next = 1'b1;
                            gap_y_next        = spawn_gap;
                            step_cnt_next     = '0;
                        end
                    end
                end
            end

            ST_OVER: begin
                if (bus.start_pulse) begin
                    state_next = ST_IDLE;
                    score_next = '0;
                    lives_next = LIVES_V;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        freeze_next = (state_next != ST_PLAY);
    end

    assign bus.state         = state_reg;
    assign bus.obstacle_step = obstacle_step_reg;
    assign bus.spawn         = spawn_reg;
    assign bus.gap_y         = gap_y_reg;
    assign bus.player_reset  = player_reset_reg;
    assign bus.freeze        = freeze_reg;
    assign bus.score         = score_reg;
    assign bus.lives         = lives_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-plus-random bench for game_sequencer, checked every cycle against
// a rule-level game model kept in plain integers.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int          P_INIT = 10;
    localparam int          P_MIN  = 6;
    localparam int          P_DEC  = 2;
    localparam int          SPD    = 5;
    localparam int          NLIVES = 3;
    localparam int          HITF   = 4;
    localparam int          GMIN   = 100;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk_148_mhz = 1'b0;
    logic rst_n       = 1'b0;
    always #5 clk_148_mhz = ~clk_148_mhz;

    game_sequencer_if bus ();

    game_sequencer #(
        .STEP_PERIOD_INIT (P_INIT),
        .PERIOD_MIN       (P_MIN),
        .PERIOD_DEC       (P_DEC),
        .SPEEDUP_EVERY    (SPD),
        .LIVES            (NLIVES),
        .HIT_FRAMES       (HITF),
        .GAP_Y_MIN        (GMIN),
        .LFSR_SEED        (SEED)
    ) dut (
        .clk_148_mhz (clk_148_mhz),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_step_cyc = 0;
    int last_spacing  = 0;
    int gap_lo = 100000;
    int gap_hi = -1;

    // Game model: mode 0 idle, 1 play, 2 frozen after hit, 3 game over.
    int          m_mode, m_score, m_lives, m_period, m_count, m_frames, m_points;
    logic [15:0] m_lfsr;
    int          e_step, e_spawn, e_preset, e_gap;

    function automatic int new_gap(input logic [15:0] r);
        return GMIN + 2 * int'(r & 16'h00FF);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_score = 0; m_lives = NLIVES; m_period = P_INIT;
        m_count = 0; m_frames = 0; m_points = 0; m_lfsr = SEED;
        e_step = 0; e_spawn = 0; e_preset = 0; e_gap = GMIN;
    endtask

    task automatic m_enter_play();
        m_mode = 1; m_count = 0; e_spawn = 1; e_preset = 1; e_gap = new_gap(m_lfsr);
    endtask

    task automatic m_edge(input bit st, input bit fr, input bit co, input bit dn);
        e_step = 0; e_spawn = 0; e_preset = 0;
        if (m_mode == 0) begin
            if (st) begin
                m_enter_play();
                m_score = 0; m_lives = NLIVES; m_period = P_INIT; m_points = 0;
            end
        end else if (m_mode == 1) begin
            if (co) begin
                m_mode = 2; m_frames = 0;
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            end else begin
                if (m_count >= m_period - 1) begin m_count = 0; e_step = 1; end
                else m_count++;
                if (dn) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    e_spawn = 1; e_gap = new_gap(m_lfsr);
                    m_points++;
                    if (m_points == SPD) begin
                        m_points = 0;
                        m_period = (m_period - P_DEC > P_MIN) ? m_period - P_DEC : P_MIN;
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (fr) begin
                m_frames++;
                if (m_frames == HITF) begin
                    if (m_lives == 0) m_mode = 3;
                    else m_enter_play();
                end
            end
        end else begin
            if (st) begin m_mode = 0; m_score = 0; m_lives = NLIVES; end
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("state",         32'(bus.state),        32'(m_mode));
        check("obstacle_step", 32'(bus.obstacle_step), 32'(e_step));
        check("spawn",         32'(bus.spawn),        32'(e_spawn));
        check("player_reset",  32'(bus.player_reset), 32'(e_preset));
        check("freeze",        32'(bus.freeze),       32'(m_mode != 1));
        check("score",         32'(bus.score),        32'(m_score));
        check("lives",         32'(bus.lives),        32'(m_lives));
        check("gap_y",         32'(bus.gap_y),        32'(e_gap));
    endtask

    task automatic tick(input bit st, input bit fr, input bit co, input bit dn);
        int g;
        bus.start_pulse = st; bus.frame_start = fr; bus.collision = co; bus.obstacle_done = dn;
        @(posedge clk_148_mhz);
        m_edge(st, fr, co, dn);
        cyc++;
        #1;
        check_all();
        if (bus.obstacle_step === 1'b1) begin
            last_spacing  = cyc - last_step_cyc;
            last_step_cyc = cyc;
        end
        if (bus.spawn === 1'b1) begin
            g = int'(bus.gap_y);
            check("gap_range_even", 32'(g >= 100 && g <= 610 && (g % 2) == 0), 32'd1);
            if (g < gap_lo) gap_lo = g;
            if (g > gap_hi) gap_hi = g;
            $display("cycle %0d spawn gap_y=%0d score=%0d lives=%0d", cyc, g, bus.score, bus.lives);
        end
    endtask

    task automatic play_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic done_burst(input int n);
        for (int i = 0; i < n; i++) begin
            play_idle($urandom_range(0, 3));
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
    endtask

    // Random frames, collision, start and done while frozen; all but frames are ignored.
    task automatic hit_wait();
        int guard = 0;
        while (m_mode == 2 && guard < 200) begin
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("hit_exit_within_budget", 32'(m_mode != 2), 32'd1);
        if (m_mode == 1) begin
            check("reentry_spawn",        32'(bus.spawn),        32'd1);
            check("reentry_player_reset", 32'(bus.player_reset), 32'd1);
            last_step_cyc = cyc;
        end
    endtask

    initial begin
        int guard;
        bus.start_pulse = 1'b0; bus.frame_start = 1'b0;
        bus.collision = 1'b0; bus.obstacle_done = 1'b0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk_148_mhz);
        #1;
        check_all();
        @(negedge clk_148_mhz);
        rst_n = 1'b1;

        // Idle then start
        play_idle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_spawn",        32'(bus.spawn),        32'd1);
        check("start_player_reset", 32'(bus.player_reset), 32'd1);
        check("start_state",        32'(bus.state),        32'd1);
        last_step_cyc = cyc;
        play_idle(35);
        check("spacing_initial", 32'(last_spacing), 32'd10);

        // Speed-up after 5 points, then clamp at the floor after 10 more
        done_burst(5);
        check("score_after_5", 32'(bus.score), 32'd5);
        play_idle(30);
        check("spacing_after_5", 32'(last_spacing), 32'd8);
        done_burst(10);
        check("score_after_15", 32'(bus.score), 32'd15);
        play_idle(30);
        check("spacing_clamped", 32'(last_spacing), 32'd6);

        // Collision and obstacle_done together: collision wins
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("coll_state", 32'(bus.state), 32'd2);
        check("coll_lives", 32'(bus.lives), 32'd2);
        check("coll_score", 32'(bus.score), 32'd15);
        check("coll_spawn", 32'(bus.spawn), 32'd0);
        hit_wait();

        // Keep colliding until the game is over
        guard = 0;
        while (m_mode != 3 && guard < 10) begin
            play_idle($urandom_range(2, 8));
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            hit_wait();
            guard++;
        end
        check("over_state", 32'(bus.state), 32'd3);
        check("over_lives", 32'(bus.lives), 32'd0);
        check("over_score", 32'(bus.score), 32'd15);
        for (int i = 0; i < 8; i++)
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("over_score_held", 32'(bus.score), 32'd15);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_state", 32'(bus.state), 32'd0);
        check("restart_score", 32'(bus.score), 32'd0);
        check("restart_lives", 32'(bus.lives), 32'd3);
        play_idle(4);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("second_start_state", 32'(bus.state), 32'd1);

        // Score saturation and gap_y spread
        gap_lo = 100000; gap_hi = -1;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            play_idle($urandom_range(0, 2));
        end
        check("score_saturated", 32'(bus.score), 32'd255);
        check("gap_values_vary", 32'(gap_hi > gap_lo), 32'd1);

        // Asynchronous reset in the middle of a round
        play_idle(7);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        repeat (3) @(posedge clk_148_mhz);
        #1;
        check_all();
        @(negedge clk_148_mhz);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_state", 32'(bus.state), 32'd0);
        check("post_reset_pulses",
              32'({bus.obstacle_step, bus.spawn, bus.player_reset}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
